// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for fetch_queue
// The slave modport is the queue's own view; master is the fetch/decode side.
interface fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic              flush;
  logic              flush_keep_head;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush, flush_keep_head,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush, flush_keep_head,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch circular buffer with redirect flush
// Optional same-cycle pass-through when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input logic          Clk,
  input logic          R,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, bypass, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & bus.in_valid & bus.out_ready & ~bus.flush;
`else
  assign bypass = 1'b0;
`endif

  // Full rejects the push even when the head leaves this same cycle.
  assign push = bus.in_valid & ~full & ~bus.flush & ~bypass;
  assign pop  = ~empty & bus.out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      if (bus.flush_keep_head && !empty) begin
        wr_ptr_d = rd_ptr_q + PTR_W'(1);
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = '0;
        end else begin
          count_d  = CNT_W'(1);
        end
      end else begin
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; count alone marks validity.
  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.in_instr;
      pc_mem[wr_ptr_q]    <= bus.in_pc;
    end
  end

  always_comb begin
    bus.out_valid = ~empty;
    bus.out_instr = empty ? '0 : instr_mem[rd_ptr_q];
    bus.out_pc    = empty ? '0 : pc_mem[rd_ptr_q];
    if (bypass) begin
      bus.out_valid = 1'b1;
      bus.out_instr = bus.in_instr;
      bus.out_pc    = bus.in_pc;
    end
  end

  assign bus.in_ready = ~full;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and random checks of fetch_queue against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic Clk;
  logic R;
  int   compared;
  int   mismatched;
  logic [63:0] mq[$];

  fetch_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .Clk (Clk),
    .R   (R),
    .bus (bus.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid        = 1'b0;
    bus.in_instr        = '0;
    bus.in_pc           = '0;
    bus.out_ready       = 1'b0;
    bus.flush           = 1'b0;
    bus.flush_keep_head = 1'b0;
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance the model, step past the edge.
  task automatic cycle(input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                       input logic ordy, input logic fl, input logic kh, input string tag);
    int          n;
    logic        bp;
    logic        popped;
    logic [63:0] e;
    bus.in_valid        = iv;
    bus.in_instr        = ii;
    bus.in_pc           = ip;
    bus.out_ready       = ordy;
    bus.flush           = fl;
    bus.flush_keep_head = kh;
    #4;
    n = mq.size();
`ifdef FETCH_QUEUE_BYPASS_EN
    bp = (n == 0) && iv && ordy && !fl;
`else
    bp = 1'b0;
`endif
    if (bp) begin
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
      chk({tag, ".instr"}, 64'(bus.out_instr), 64'(ii));
      chk({tag, ".pc"},    64'(bus.out_pc),    64'(ip));
    end else begin
      e = (n != 0) ? mq[0] : 64'd0;
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'(n != 0));
      chk({tag, ".instr"}, 64'(bus.out_instr), 64'(e[63:32]));
      chk({tag, ".pc"},    64'(bus.out_pc),    64'(e[31:0]));
    end
    chk({tag, ".count"}, 64'(bus.count),    64'(n));
    chk({tag, ".ready"}, 64'(bus.in_ready), 64'(n < DEPTH));

    popped = (n != 0) && ordy;
    if (fl) begin
      if (kh && n != 0 && !popped) begin
        e = mq[0];
        mq.delete();
        mq.push_back(e);
      end else begin
        mq.delete();
      end
    end else begin
      if (popped) void'(mq.pop_front());
      if (iv && n < DEPTH && !bp) mq.push_back({ii, ip});
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic empty_queue();
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, "empty");
  endtask

  task automatic load3(input logic [31:0] base_pc);
    empty_queue();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'hA000_0000 + 32'(i), base_pc + 32'(4 * i), 1'b0, 1'b0, 1'b0, "load");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    idle();
    R = 1'b1;
    #12;
    chk("rst.count", 64'(bus.count), 64'(0));
    chk("rst.valid", 64'(bus.out_valid), 64'(0));
    chk("rst.instr", 64'(bus.out_instr), 64'(0));
    chk("rst.pc",    64'(bus.out_pc), 64'(0));
    chk("rst.ready", 64'(bus.in_ready), 64'(1));
    R = 1'b0;
    @(posedge Clk);
    #1;

    // Fill to DEPTH, attempt an overflow push, then drain through the wrap point.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hC000_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b0, "fill");
    cycle(1'b1, 32'hC000_0004, 32'd16, 1'b0, 1'b0, 1'b0, "overflow");
    cycle(1'b1, 32'hC000_0004, 32'd16, 1'b1, 1'b0, 1'b0, "full_pop_push");
    cycle(1'b1, 32'hC000_0004, 32'd16, 1'b1, 1'b0, 1'b0, "wrap_push16");
    cycle(1'b1, 32'hC000_0005, 32'd20, 1'b1, 1'b0, 1'b0, "wrap_push20");
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, "drain");

    // Steady push+pop at occupancy 2.
    cycle(1'b1, 32'hD000_0000, 32'h100, 1'b0, 1'b0, 1'b0, "pp_load");
    cycle(1'b1, 32'hD000_0001, 32'h104, 1'b0, 1'b0, 1'b0, "pp_load");
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'hD000_0002 + 32'(i), 32'h108 + 32'(4 * i), 1'b1, 1'b0, 1'b0, "pushpop");

    // Flush variants, each with a push offered in the flush cycle.
    load3(32'd8);
    cycle(1'b1, 32'hEEEE_0000, 32'h200, 1'b0, 1'b1, 1'b1, "flush_keep");
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "after_keep");
    load3(32'd8);
    cycle(1'b1, 32'hEEEE_0001, 32'h204, 1'b0, 1'b1, 1'b0, "flush_clear");
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "after_clear");
    load3(32'd8);
    cycle(1'b1, 32'hEEEE_0002, 32'h208, 1'b1, 1'b1, 1'b1, "flush_keep_pop");
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "after_keep_pop");
    cycle(1'b1, 32'hEEEE_0003, 32'h20C, 1'b0, 1'b1, 1'b1, "flush_keep_empty");
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "after_keep_empty");

    // Stall holds the head steady.
    cycle(1'b1, 32'h8C00_0001, 32'h300, 1'b0, 1'b0, 1'b0, "stall_load");
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "stall");
    empty_queue();

    // Empty queue with a ready consumer: pass-through or one-cycle latency.
    cycle(1'b1, 32'h1234_5678, 32'h400, 1'b1, 1'b0, 1'b0, "bypass");
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "bypass_next");
    empty_queue();

    // Asynchronous reset between edges with three words queued.
    load3(32'h500);
    idle();
    #2;
    R = 1'b1;
    #1;
    chk("arst.count", 64'(bus.count), 64'(0));
    chk("arst.valid", 64'(bus.out_valid), 64'(0));
    chk("arst.instr", 64'(bus.out_instr), 64'(0));
    chk("arst.ready", 64'(bus.in_ready), 64'(1));
    mq.delete();
    #1;
    R = 1'b0;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
